// File: rtl/trackball_quad_encoder.sv
// Signed mouse deltas -> two-axis quadrature A/B; build with TRACKBALL_ACCEL_EN for double edge rate at large backlog.
// Latency: first edge STEP_DIV clks after a delta reaches an idle axis, then one edge per STEP_DIV clks.
// Backpressure: none; every delta_vld strobe is absorbed into a saturating pending counter (ovf flags clamping).

module trackball_quad_axis #(
    parameter int STEP_DIV     = 2500,
    parameter int ACC_W        = 10,
    parameter int ACCEL_THRESH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              delta_vld,
    input  logic signed [8:0] delta,
    output logic              a,
    output logic              b,
    output logic              busy,
    output logic              clamp
);
    localparam int DIV_W = $clog2(STEP_DIV);
    localparam int SUM_W = ACC_W + 2;
    localparam logic signed [ACC_W-1:0] P_LIM = ACC_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] P_MAX = SUM_W'(P_LIM);
    localparam logic signed [SUM_W-1:0] P_MIN = -P_MAX;

    generate
        if ((STEP_DIV % 2) != 0 || STEP_DIV < 4 || ACC_W < 9 || ACCEL_THRESH < 1) begin : g_bad_param
            $error("trackball_quad_axis: illegal parameter set");
        end
    endgenerate

    logic signed [ACC_W-1:0] p;
    logic signed [ACC_W-1:0] p_nxt;
    logic [DIV_W-1:0]        div;
    logic [DIV_W-1:0]        tc;
    logic                    step;
    logic signed [SUM_W-1:0] d_ext;
    logic signed [SUM_W-1:0] s_ext;
    logic signed [SUM_W-1:0] sum;

`ifdef TRACKBALL_ACCEL_EN
    logic [ACC_W-1:0] mag;
    assign mag = p[ACC_W-1] ? ACC_W'(-p) : ACC_W'(p);
    // Terminal count re-evaluated every clk; '>=' in step absorbs a drop into the fast rate.
    assign tc  = (mag >= ACC_W'(ACCEL_THRESH)) ? DIV_W'(STEP_DIV / 2 - 1) : DIV_W'(STEP_DIV - 1);
`else
    assign tc  = DIV_W'(STEP_DIV - 1);
`endif

    assign busy = (p != '0);
    assign step = enable && busy && (div >= tc);

    always_comb begin
        s_ext = '0;
        if (step) begin
            s_ext = p[ACC_W-1] ? '1 : SUM_W'(1);
        end
        d_ext = delta_vld ? SUM_W'(delta) : '0;
        sum   = SUM_W'(p) + d_ext - s_ext;
        clamp = 1'b0;
        p_nxt = sum[ACC_W-1:0];
        if (sum > P_MAX) begin
            clamp = 1'b1;
            p_nxt = P_LIM;
        end else if (sum < P_MIN) begin
            clamp = 1'b1;
            p_nxt = -P_LIM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p   <= '0;
            div <= '0;
            a   <= 1'b0;
            b   <= 1'b0;
        end else begin
            p <= p_nxt;
            // A reversal keeps the divider running; only landing on zero restarts it.
            if (!enable || !busy || step || (p_nxt == '0)) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end
            if (step) begin
                if (!p[ACC_W-1]) begin
                    a <= ~b;
                    b <= a;
                end else begin
                    a <= b;
                    b <= ~a;
                end
            end
        end
    end
endmodule

module trackball_quad_encoder #(
    parameter int STEP_DIV     = 2500,
    parameter int ACC_W        = 10,
    parameter int ACCEL_THRESH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              delta_vld,
    input  logic signed [8:0] dx,
    input  logic signed [8:0] dy,
    input  logic              ovf_clr,
    output logic              x_a,
    output logic              x_b,
    output logic              y_a,
    output logic              y_b,
    output logic              x_busy,
    output logic              y_busy,
    output logic              ovf
);
    logic x_clamp;
    logic y_clamp;

    trackball_quad_axis #(
        .STEP_DIV(STEP_DIV), .ACC_W(ACC_W), .ACCEL_THRESH(ACCEL_THRESH)
    ) u_x (
        .clk(clk), .reset(reset), .enable(enable), .delta_vld(delta_vld), .delta(dx),
        .a(x_a), .b(x_b), .busy(x_busy), .clamp(x_clamp)
    );

    trackball_quad_axis #(
        .STEP_DIV(STEP_DIV), .ACC_W(ACC_W), .ACCEL_THRESH(ACCEL_THRESH)
    ) u_y (
        .clk(clk), .reset(reset), .enable(enable), .delta_vld(delta_vld), .delta(dy),
        .a(y_a), .b(y_b), .busy(y_busy), .clamp(y_clamp)
    );

    // A fresh clamp wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (x_clamp || y_clamp) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
endmodule
